// File: rtl/fixed_add_sub_signed_unit.sv
// Registered signed fixed-point add/subtract with signed compare flags.
// Define FIXED_ADD_SUB_SATURATE_EN to saturate on overflow; otherwise the result wraps.
module fixed_add_sub_signed_unit #(
  parameter int unsigned INTEGER_WIDTH = 2,
  parameter int unsigned DECIMAL_WIDTH = 20,
  parameter int unsigned DATA_WIDTH    = INTEGER_WIDTH + DECIMAL_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clk_en,
  input  logic [DATA_WIDTH-1:0] dataa,
  input  logic [DATA_WIDTH-1:0] datab,
  input  logic                  add_sub,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  aeb,
  output logic                  agb,
  output logic                  overflow
);

  localparam int unsigned MSB = DATA_WIDTH - 1;
  localparam logic [DATA_WIDTH-1:0] MAX_POS = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] MAX_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  // The integer/fraction split only positions the implicit binary point.
  if (INTEGER_WIDTH < 1 || DATA_WIDTH != INTEGER_WIDTH + DECIMAL_WIDTH) begin : g_bad_width
    $error("fixed_add_sub_signed_unit: DATA_WIDTH must equal INTEGER_WIDTH + DECIMAL_WIDTH");
  end

  logic [DATA_WIDTH-1:0] raw_c;
  logic [DATA_WIDTH-1:0] result_c;
  logic                  overflow_c;
  logic                  aeb_c;
  logic                  agb_c;

  // Arithmetic, overflow detection and comparison for the next output set.
  always_comb begin
    raw_c      = '0;
    result_c   = '0;
    overflow_c = 1'b0;
    aeb_c      = 1'b0;
    agb_c      = 1'b0;

    if (add_sub) begin
      raw_c      = DATA_WIDTH'(dataa + datab);
      overflow_c = (dataa[MSB] == datab[MSB]) && (raw_c[MSB] != dataa[MSB]);
    end else begin
      raw_c      = DATA_WIDTH'(dataa - datab);
      overflow_c = (dataa[MSB] != datab[MSB]) && (raw_c[MSB] != dataa[MSB]);
    end

`ifdef FIXED_ADD_SUB_SATURATE_EN
    // On overflow the true result always has the sign of A.
    if (overflow_c) begin
      result_c = dataa[MSB] ? MAX_NEG : MAX_POS;
    end else begin
      result_c = raw_c;
    end
`else
    result_c = raw_c;
`endif

    aeb_c = (dataa == datab);
    agb_c = ($signed(dataa) > $signed(datab));
  end

  // Output registers: synchronous reset wins over an enabled load.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      result   <= '0;
      aeb      <= 1'b0;
      agb      <= 1'b0;
      overflow <= 1'b0;
    end else if (clk_en) begin
      result   <= result_c;
      aeb      <= aeb_c;
      agb      <= agb_c;
      overflow <= overflow_c;
    end
  end

`ifndef FIXED_ADD_SUB_SATURATE_EN
  // Saturation bounds are only needed by the saturating build.
  logic unused_bounds;
  assign unused_bounds = ^{MAX_POS, MAX_NEG};
`endif

endmodule

// File: tb/tb_fixed_add_sub_signed_unit.sv
// Directed self-checking bench for fixed_add_sub_signed_unit (22-bit default).
module tb_fixed_add_sub_signed_unit;

  localparam int unsigned DW = 22;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          clk_en;
  logic [DW-1:0] dataa;
  logic [DW-1:0] datab;
  logic          add_sub;
  logic [DW-1:0] result;
  logic          aeb;
  logic          agb;
  logic          overflow;

  int checks   = 0;
  int failures = 0;

  fixed_add_sub_signed_unit dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .clk_en   (clk_en),
    .dataa    (dataa),
    .datab    (datab),
    .add_sub  (add_sub),
    .result   (result),
    .aeb      (aeb),
    .agb      (agb),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

`ifdef FIXED_ADD_SUB_SATURATE_EN
  localparam logic [DW-1:0] OVF_POS_ADD = 22'h1FFFFF;
  localparam logic [DW-1:0] OVF_NEG_SUB = 22'h200000;
  localparam logic [DW-1:0] OVF_POS_SUB = 22'h1FFFFF;
  localparam logic [DW-1:0] OVF_NEG_ADD = 22'h200000;
`else
  localparam logic [DW-1:0] OVF_POS_ADD = 22'h240000;
  localparam logic [DW-1:0] OVF_NEG_SUB = 22'h1FFFFF;
  localparam logic [DW-1:0] OVF_POS_SUB = 22'h200000;
  localparam logic [DW-1:0] OVF_NEG_ADD = 22'h1FFFFF;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive on the falling edge, then sample 1 time unit after the next rising edge.
  task automatic step(input logic rn, input logic en, input logic [DW-1:0] a,
                      input logic [DW-1:0] b, input logic as);
    @(negedge clk);
    reset_n = rn;
    clk_en  = en;
    dataa   = a;
    datab   = b;
    add_sub = as;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [DW-1:0] r, input logic e,
                         input logic g, input logic o);
    chk({tag, ".result"},   32'(result),   32'(r));
    chk({tag, ".aeb"},      32'(aeb),      32'(e));
    chk({tag, ".agb"},      32'(agb),      32'(g));
    chk({tag, ".overflow"}, 32'(overflow), 32'(o));
  endtask

  initial begin
    reset_n = 1'b0;
    clk_en  = 1'b0;
    dataa   = '0;
    datab   = '0;
    add_sub = 1'b1;

    // Reset with enable high and live operands
    step(1'b0, 1'b1, 22'h0C0000, 22'h040000, 1'b1);
    chk_all("reset", 22'h000000, 1'b0, 1'b0, 1'b0);

    // 0.75 + 0.25 = 1.0, one edge after release
    step(1'b1, 1'b1, 22'h0C0000, 22'h040000, 1'b1);
    chk_all("add", 22'h100000, 1'b0, 1'b1, 1'b0);

    // 0.25 - 0.75 = -0.5
    step(1'b1, 1'b1, 22'h040000, 22'h0C0000, 1'b0);
    chk_all("sub", 22'h380000, 1'b0, 1'b0, 1'b0);

    // -2.0 vs +2.0-lsb: signed compare, sum = -1 lsb
    step(1'b1, 1'b1, 22'h200000, 22'h1FFFFF, 1'b1);
    chk_all("signed_cmp", 22'h3FFFFF, 1'b0, 1'b0, 1'b0);

    // Equality
    step(1'b1, 1'b1, 22'h3FFFFF, 22'h3FFFFF, 1'b0);
    chk_all("equal", 22'h000000, 1'b1, 1'b0, 1'b0);

    // Positive add overflow: 1.75 + 0.5
    step(1'b1, 1'b1, 22'h1C0000, 22'h080000, 1'b1);
    chk_all("ovf_add_pos", OVF_POS_ADD, 1'b0, 1'b1, 1'b1);

    // Negative subtract overflow: -2.0 - lsb
    step(1'b1, 1'b1, 22'h200000, 22'h000001, 1'b0);
    chk_all("ovf_sub_neg", OVF_NEG_SUB, 1'b0, 1'b0, 1'b1);

    // Positive subtract overflow: max - (-1 lsb)
    step(1'b1, 1'b1, 22'h1FFFFF, 22'h3FFFFF, 1'b0);
    chk_all("ovf_sub_pos", OVF_POS_SUB, 1'b0, 1'b1, 1'b1);

    // Negative add overflow: -2.0 + (-1 lsb)
    step(1'b1, 1'b1, 22'h200000, 22'h3FFFFF, 1'b1);
    chk_all("ovf_add_neg", OVF_NEG_ADD, 1'b0, 1'b0, 1'b1);

    // Boundary without overflow: max + 0, and add_sub does not affect compare
    step(1'b1, 1'b1, 22'h1FFFFF, 22'h000000, 1'b0);
    chk_all("max_minus_zero", 22'h1FFFFF, 1'b0, 1'b1, 1'b0);

    // Enable hold
    step(1'b1, 1'b1, 22'h100000, 22'h000000, 1'b1);
    chk_all("hold_load", 22'h100000, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 22'h000005, 22'h000005, 1'b0);
    chk_all("hold1", 22'h100000, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 22'h1C0000, 22'h080000, 1'b1);
    chk_all("hold2", 22'h100000, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 22'h200000, 22'h1FFFFF, 1'b0);
    chk_all("hold3", 22'h100000, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 22'h000001, 22'h000002, 1'b1);
    chk_all("hold_release", 22'h000003, 1'b0, 1'b0, 1'b0);

    // Mid-stream reset with enable high discards the operation
    step(1'b1, 1'b1, 22'h1C0000, 22'h080000, 1'b1);
    chk_all("pre_reset", OVF_POS_ADD, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 22'h0C0000, 22'h040000, 1'b1);
    chk_all("reset_mid", 22'h000000, 1'b0, 1'b0, 1'b0);

    // Reset with enable low also clears
    step(1'b1, 1'b1, 22'h3FFFFF, 22'h3FFFFF, 1'b1);
    chk_all("pre_reset2", 22'h3FFFFE, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 22'h3FFFFF, 22'h3FFFFF, 1'b1);
    chk_all("reset_no_en", 22'h000000, 1'b0, 1'b0, 1'b0);

    // Back-to-back operation after reset
    step(1'b1, 1'b1, 22'h040000, 22'h0C0000, 1'b1);
    chk_all("after_reset", 22'h100000, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
